// File: rtl/conv_pkg.sv
// Shared types and default geometry for the convolution window sequencer.
package conv_pkg;

  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;
  localparam int DEF_K     = 3;

  localparam int COL_W = $clog2(DEF_IMG_W);
  localparam int ROW_W = $clog2(DEF_IMG_H);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/conv_window_ctrl_lb_occ_tracker.sv
// Occupancy counter and pop generation for one line buffer.
// The optional sticky check is enabled by CONV_WIN_CTRL_ERR_EN.
module lb_occ_tracker #(
  parameter int DEPTH = 28
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  output logic pop,
  output logic err
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  logic [OCC_W-1:0] occ;

  // Once full, every push shifts one row-old pixel out on the same cycle.
  assign pop = push && (occ == FULL);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      occ <= '0;
    end else if (push && !pop && (occ != FULL)) begin
      occ <= occ + 1'b1;
    end else if (pop && !push && (occ != '0)) begin
      occ <= occ - 1'b1;
    end
  end

`ifdef CONV_WIN_CTRL_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (((occ == FULL) && push && !pop) || ((occ == '0) && pop)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/conv_window_ctrl.sv
// Raster-position sequencer for a KxK line-buffer window chain.
// Optional occupancy error flag: define CONV_WIN_CTRL_ERR_EN.
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int K     = DEF_K
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     pix_vld,
  output logic                     pix_rdy,
  output logic [K-2:0]             lb_push,
  output logic [K-2:0]             lb_pop,
  output logic                     win_vld,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FILLD = RW'(K - 2);
  localparam logic [CW-1:0] COL_WIN   = CW'(K - 1);
  localparam logic [RW-1:0] ROW_WIN   = RW'(K - 1);

  state_t          state, state_nxt;
  logic            acc, row_end, win_hit;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [K-2:0]    lb_err;

  assign acc     = pix_vld && pix_rdy;
  assign row_end = acc && (col == COL_LAST);
  assign win_hit = acc && (row >= ROW_WIN) && (col >= COL_WIN);

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: default first so no path through always_comb leaves a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_FILL;
      ST_FILL:  if (row_end && (row == ROW_FILLD)) state_nxt = ST_RUN;
      ST_RUN:   if (row_end && (row == ROW_LAST)) state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pix_rdy = (state == ST_FILL) || (state == ST_RUN);
    busy    = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if ((state == ST_IDLE) && start) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // frame_done trails the FLUSH cycle so it lands just after the last window.
  always_ff @(posedge clk) begin
    if (!rst) begin
      win_vld    <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      win_vld    <= win_hit;
      frame_done <= (state == ST_FLUSH);
      if (win_hit) begin
        win_row <= row;
        win_col <= col;
      end
    end
  end

  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    if (i == 0) begin : g_src
      assign lb_push[i] = acc;
    end else begin : g_dly
      // Upstream buffer's pop data appears one cycle later (read latency).
      logic push_q;
      always_ff @(posedge clk) begin
        if (!rst) push_q <= 1'b0;
        else      push_q <= lb_pop[i-1];
      end
      assign lb_push[i] = push_q;
    end

    lb_occ_tracker #(.DEPTH(IMG_W)) u_occ (
      .clk  (clk),
      .rst  (rst),
      .push (lb_push[i]),
      .pop  (lb_pop[i]),
      .err  (lb_err[i])
    );
  end

  assign err = |lb_err;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed self-checking bench for conv_window_ctrl at default geometry.
module tb_conv_window_ctrl;
  import conv_pkg::*;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 3;
  localparam int N_PIX = IMG_W * IMG_H;
  localparam int N_WIN = (IMG_H - K + 1) * (IMG_W - K + 1);

  logic             clk = 1'b0;
  logic             rst, start, pix_vld;
  logic             pix_rdy, win_vld, busy, frame_done, err;
  logic [K-2:0]     lb_push, lb_pop;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;

  int n_chk = 0;
  int n_err = 0;

  // Bench-side reference of the raster position and expected strobes.
  int   macc_n, total_acc, mrow, mcol, pend_r, pend_c;
  logic pend_vld, prev_pop0;
  int   n_win, first_win_acc, first_win_row, first_win_col, first_pop_acc;

  conv_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pix_vld    (pix_vld),
    .pix_rdy    (pix_rdy),
    .lb_push    (lb_push),
    .lb_pop     (lb_pop),
    .win_vld    (win_vld),
    .win_row    (win_row),
    .win_col    (win_col),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    macc_n = 0; mrow = 0; mcol = 0;
    pend_vld = 1'b0; prev_pop0 = 1'b0;
    n_win = 0; first_win_acc = 0; first_win_row = -1; first_win_col = -1;
    first_pop_acc = 0;
  endtask

  // One clock cycle inside FILL/RUN with pix_vld = v.
  task automatic px(input logic v);
    logic a, p;
    pix_vld = v;
    #1;
    chk("win_vld", win_vld, pend_vld);
    if (pend_vld) begin
      chk("win_row", win_row, pend_r);
      chk("win_col", win_col, pend_c);
    end
    if (win_vld === 1'b1) begin
      if (n_win == 0) begin
        first_win_acc = macc_n;
        first_win_row = int'(win_row);
        first_win_col = int'(win_col);
      end
      n_win++;
    end
    chk("pix_rdy_frame", pix_rdy, 1);
    a = v;
    p = a && (total_acc >= IMG_W);
    chk("lb_push0", lb_push[0], a);
    chk("lb_pop0", lb_pop[0], p);
    chk("lb_push1_follows_pop0", lb_push[1], prev_pop0);
    if ((lb_pop[0] === 1'b1) && (first_pop_acc == 0)) first_pop_acc = macc_n + 1;
    prev_pop0 = p;
    pend_vld  = a && (mrow >= K - 1) && (mcol >= K - 1);
    pend_r    = mrow;
    pend_c    = mcol;
    if (a) begin
      macc_n++;
      total_acc++;
      if (mcol == IMG_W - 1) begin
        mcol = 0;
        mrow++;
      end else begin
        mcol++;
      end
    end
    #1;
    tick();
  endtask

  // FLUSH cycle, then the frame_done cycle, then one idle cycle.
  task automatic finish_frame();
    pix_vld = 1'b1;
    #1;
    chk("last_win_vld", win_vld, 1);
    chk("last_win_row", win_row, IMG_H - 1);
    chk("last_win_col", win_col, IMG_W - 1);
    if (win_vld === 1'b1) n_win++;
    chk("flush_pix_rdy", pix_rdy, 0);
    chk("flush_no_push", lb_push[0], 0);
    chk("flush_push1", lb_push[1], prev_pop0);
    chk("flush_busy", busy, 1);
    chk("flush_no_done", frame_done, 0);
    tick();
    chk("frame_done", frame_done, 1);
    chk("done_busy", busy, 0);
    chk("done_win_vld", win_vld, 0);
    chk("idle_pix_rdy", pix_rdy, 0);
    chk("idle_no_push", lb_push, 0);
    tick();
    pix_vld = 1'b0;
    chk("frame_done_clear", frame_done, 0);
    chk("win_count", n_win, N_WIN);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; pix_vld = 1'b0;
    total_acc = 0;
    repeat (3) tick();
    chk("rst_pix_rdy", pix_rdy, 0);
    chk("rst_lb_push", lb_push, 0);
    chk("rst_lb_pop", lb_pop, 0);
    chk("rst_win_vld", win_vld, 0);
    chk("rst_win_row", win_row, 0);
    chk("rst_win_col", win_col, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err", err, 0);

    rst = 1'b1;
    pix_vld = 1'b1;
    #1;
    chk("idle_rdy_low", pix_rdy, 0);
    chk("idle_ignores_vld", lb_push[0], 0);
    tick();
    pix_vld = 1'b0;

    // Frame 1: back-to-back pixels.
    start_frame();
    while (macc_n < N_PIX) px(1'b1);
    chk("f1_first_win_acc", first_win_acc, 59);
    chk("f1_first_win_row", first_win_row, 2);
    chk("f1_first_win_col", first_win_col, 2);
    chk("f1_first_pop_acc", first_pop_acc, 29);
    finish_frame();

    // Frame 2: random gaps, stale buffers stay full, start during RUN ignored.
    start_frame();
    for (int c = 0; (c < 6000) && (macc_n < N_PIX); c++) begin
      start = (c == 300);
      px(1'(($urandom_range(0, 1))));
      if (c == 300) chk("start_in_run_busy", busy, 1);
    end
    start = 1'b0;
    chk("f2_all_pixels", macc_n, N_PIX);
    chk("f2_first_win_row", first_win_row, 2);
    chk("f2_first_win_col", first_win_col, 2);
    chk("f2_pop_from_first", first_pop_acc, 1);
    finish_frame();

    // Frame 3: reset at pixel 400.
    start_frame();
    while (macc_n < 400) px(1'b1);
    rst = 1'b0;
    pix_vld = 1'b1;
    tick();
    chk("mid_rst_pix_rdy", pix_rdy, 0);
    chk("mid_rst_lb_push", lb_push, 0);
    chk("mid_rst_lb_pop", lb_pop, 0);
    chk("mid_rst_win_vld", win_vld, 0);
    chk("mid_rst_win_row", win_row, 0);
    chk("mid_rst_win_col", win_col, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    rst = 1'b1;
    pix_vld = 1'b0;
    total_acc = 0;
    tick();

    // Frame 4: full frame after the mid-frame reset.
    start_frame();
    while (macc_n < N_PIX) px(1'b1);
    chk("f4_first_win_acc", first_win_acc, 59);
    chk("f4_first_pop_acc", first_pop_acc, 29);
    finish_frame();

`ifdef CONV_WIN_CTRL_ERR_EN
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("err_clear_before", err, 0);
    force dut.g_lb[0].u_occ.pop = 1'b1;
    tick();
    release dut.g_lb[0].u_occ.pop;
    chk("err_set", err, 1);
    repeat (5) tick();
    chk("err_sticky", err, 1);
    rst = 1'b0;
    tick();
    chk("err_cleared_by_rst", err, 0);
    rst = 1'b1;
    tick();
`else
    chk("err_tied_low", err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
